// File: rtl/uart_rx_perif.sv
// UART receiver peripheral for the 6502 bus.
// Deserialises 8N1 frames from rx_pin into a small FIFO and exposes data,
// status, control and count registers through a 2-bit address window.
module uart_rx_perif #(
  parameter int DELAY_FRAMES = 234,  // clk cycles per bit
  parameter int FIFO_DEPTH   = 4     // power of two, minimum 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] AB,
  input  logic       CS,
  input  logic       WE,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rx_pin,
  output logic       irq
);

  localparam int CW = $clog2(DELAY_FRAMES);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_BIT = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(DELAY_FRAMES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Receiver state
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;

  // Flags and bus edge detection
  logic          overrun;
  logic          frame_err;
  logic          irq_en;
  logic          cs_q;

  // Decoded events for this cycle
  logic          access;
  logic          pop;
  logic          ctrl_wr;
  logic          stop_done;
  logic          push;
  logic          ovr_set;
  logic          fe_set;
  logic [7:0]    status;
  logic [7:0]    rd_data;
  logic          unused_di;

  assign unused_di = ^DI[6:2];

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // One register action per CS assertion: only its first cycle counts.
  assign access  = CS & ~cs_q;
  assign pop     = access & ~WE & (AB == 2'd0) & ~empty;
  assign ctrl_wr = access & WE & (AB == 2'd2);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign stop_done = (state == STOP) && (cnt == FULL_BIT);
  assign push      = stop_done & rx_s & (~full | pop);
  assign ovr_set   = stop_done & rx_s & full & ~pop;
  assign fe_set    = stop_done & ~rx_s;

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
    end
  end

  // Frame deserialiser: start-bit qualify, 8 data bits LSB-first, stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_BIT) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_BIT) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid stop bit so a following start edge is caught early.
          if (cnt == FULL_BIT) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO data array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count and pointers alone decide
    // which entries are valid, so stale contents are never observed.
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky flags (set beats a simultaneous clear), control and interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      cs_q <= CS;
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ctrl_wr && DI[0]) begin
        overrun <= 1'b0;
      end
      if (fe_set) begin
        frame_err <= 1'b1;
      end else if (ctrl_wr && DI[1]) begin
        frame_err <= 1'b0;
      end
      if (ctrl_wr) begin
        irq_en <= DI[7];
      end
      irq <= irq_en & ~empty;
    end
  end

  assign status = {(state != IDLE), 2'b00, irq_en, frame_err, overrun, full, ~empty};

  // Read mux over the register window; the FIFO head reads 0x00 when empty.
  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch forms.
    rd_data = 8'h00;
    case (AB)
      2'd0: rd_data = empty ? 8'h00 : mem[rd_ptr];
      2'd1: rd_data = status;
      2'd2: rd_data = {irq_en, 7'b0};
      2'd3: rd_data = 8'(count);
      default: rd_data = 8'h00;
    endcase
  end

  assign DO = (CS && !WE) ? rd_data : 8'bz;

endmodule

// File: tb/tb_uart_rx_perif.sv
// Directed testbench for uart_rx_perif: reset state, frame reception and
// latency, FIFO overrun, framing error, start-bit glitch, irq and mid-frame reset.
module tb_uart_rx_perif;

  localparam int D = 234;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] AB;
  logic       CS;
  logic       WE;
  logic [7:0] DI;
  wire  [7:0] DO;
  logic       rx_pin;
  logic       irq;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_rx_perif #(.DELAY_FRAMES(D), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .AB     (AB),
    .CS     (CS),
    .WE     (WE),
    .DI     (DI),
    .DO     (DO),
    .rx_pin (rx_pin),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
    CS = 1'b1; WE = 1'b0; AB = addr;
    #1 data = DO;
    tick(1);
    CS = 1'b0;
    tick(1);
  endtask

  task automatic bus_read_hold(input logic [1:0] addr, input int n, output logic [7:0] data);
    CS = 1'b1; WE = 1'b0; AB = addr;
    #1 data = DO;
    tick(n);
    CS = 1'b0;
    tick(1);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
    CS = 1'b1; WE = 1'b1; AB = addr; DI = data;
    tick(1);
    CS = 1'b0; WE = 1'b0;
    tick(1);
  endtask

  // Start bit and eight data bits; returns at the start of the stop bit.
  task automatic send_data_bits(input logic [7:0] b);
    rx_pin = 1'b0;
    tick(D);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(D);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    send_data_bits(b);
    rx_pin = stop_v;
    tick(D);
    rx_pin = 1'b1;
  endtask

  // Hold a STATUS read open until not-empty shows; returns cycles since c0.
  task automatic poll_not_empty(input int c0, output int lat);
    lat = -1;
    CS = 1'b1; WE = 1'b0; AB = 2'd1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (DO[0] === 1'b1) begin
        lat = cyc - c0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] rd;
  int         c0;
  int         lat;

  initial begin
    rst_n = 1'b0; CS = 1'b0; WE = 1'b0; AB = 2'd0; DI = 8'h00; rx_pin = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Reset state
    check("rst_irq", {7'b0, irq}, 8'h00);
    n_assert++;
    assert (DO === 8'bz)
    else begin
      n_fail++;
      $error("FAIL rst_do_z: observed %h expected zz", DO);
    end
    bus_read(2'd1, rd); check("rst_status", rd, 8'h00);
    bus_read(2'd3, rd); check("rst_count",  rd, 8'h00);
    bus_read(2'd2, rd); check("rst_ctrl",   rd, 8'h00);

    // Single frame 0x55 with latency measurement
    c0 = cyc;
    send_data_bits(8'h55);
    rx_pin = 1'b1;
    poll_not_empty(c0, lat);
    n_assert++;
    assert (lat >= 2223 && lat <= 2227)
    else begin
      n_fail++;
      $error("FAIL latency: observed %0d expected 2225+-2", lat);
    end
    CS = 1'b0;
    tick(1);
    bus_read(2'd3, rd); check("f55_count1", rd, 8'h01);
    bus_read(2'd0, rd); check("f55_data",   rd, 8'h55);
    bus_read(2'd3, rd); check("f55_count0", rd, 8'h00);
    tick(300);

    // Five back-to-back frames into a 4-deep FIFO
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1);
    tick(10);
    bus_read(2'd1, rd); check("ovr_status", rd, 8'h07);
    bus_read(2'd3, rd); check("ovr_count",  rd, 8'h04);
    bus_read_hold(2'd0, 3, rd); check("ovr_hold_data", rd, 8'h01);
    bus_read(2'd3, rd); check("ovr_hold_count", rd, 8'h03);
    bus_read(2'd0, rd); check("ovr_data2", rd, 8'h02);
    bus_read(2'd0, rd); check("ovr_data3", rd, 8'h03);
    bus_read(2'd0, rd); check("ovr_data4", rd, 8'h04);
    bus_read(2'd0, rd); check("ovr_empty", rd, 8'h00);
    bus_read(2'd1, rd); check("ovr_status2", rd, 8'h04);
    bus_write(2'd2, 8'h01);
    bus_read(2'd1, rd); check("ovr_cleared", rd, 8'h00);

    // Framing error: stop bit low
    send_frame(8'hA3, 1'b0);
    tick(400);
    bus_read(2'd1, rd); check("fe_status", rd, 8'h08);
    bus_read(2'd3, rd); check("fe_count",  rd, 8'h00);
    bus_write(2'd2, 8'h02);
    bus_read(2'd1, rd); check("fe_cleared", rd, 8'h00);

    // 40-cycle low glitch
    rx_pin = 1'b0;
    tick(20);
    bus_read(2'd1, rd); check("gl_busy", rd, 8'h80);
    tick(18);
    rx_pin = 1'b1;
    tick(300);
    bus_read(2'd1, rd); check("gl_status", rd, 8'h00);
    bus_read(2'd3, rd); check("gl_count",  rd, 8'h00);

    // Interrupt on receive of 0x7E
    bus_write(2'd2, 8'h80);
    bus_read(2'd2, rd); check("irq_ctrl",   rd, 8'h80);
    bus_read(2'd1, rd); check("irq_status", rd, 8'h10);
    c0 = cyc;
    send_data_bits(8'h7E);
    rx_pin = 1'b1;
    poll_not_empty(c0, lat);
    check("irq_seen", {7'b0, lat > 0}, 8'h01);
    check("irq_lag0", {7'b0, irq}, 8'h00);
    tick(1);
    check("irq_set", {7'b0, irq}, 8'h01);
    CS = 1'b0;
    tick(1);
    CS = 1'b1; WE = 1'b0; AB = 2'd0;
    #1 check("irq_data", DO, 8'h7E);
    tick(1);
    check("irq_hold", {7'b0, irq}, 8'h01);
    CS = 1'b0;
    tick(1);
    check("irq_clr", {7'b0, irq}, 8'h00);

    // Reset in the middle of the data bits
    rx_pin = 1'b0;
    tick(D);
    tick(D);
    rx_pin = 1'b1;
    tick(D / 2);
    bus_read(2'd1, rd); check("mr_busy", rd, 8'h90);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3000);
    bus_read(2'd1, rd); check("mr_status", rd, 8'h00);
    bus_read(2'd3, rd); check("mr_count",  rd, 8'h00);
    check("mr_irq", {7'b0, irq}, 8'h00);

    // Receiver works normally after the reset
    send_frame(8'h3C, 1'b1);
    tick(10);
    bus_read(2'd0, rd); check("post_data", rd, 8'h3C);
    bus_read(2'd3, rd); check("post_count", rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
